// File: rtl/timer_pkg.sv
// Shared widths, a write-bus payload type and prescaler helper functions
// for the 64-bit timer counter.
//   eff_exp   : effective prescaler exponent from (div_en, div_val)
//   exp_limit : terminal prescaler value 2^e - 1 for an exponent
//   div_limit : terminal prescaler value directly from (div_en, div_val)
package timer_pkg;

  localparam int unsigned CNT_W   = 64;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DIV_W   = 4;
  localparam int unsigned DIV_MAX = 8;
  localparam int unsigned STRB_N  = 4;
  localparam int unsigned PRE_W   = 8;

  // One APB data-word write as seen by the counter.
  typedef struct packed {
    logic [STRB_N-1:0] strb;
    logic [WORD_W-1:0] data;
  } tdr_wr_t;

  // Exponent is 0 with the prescaler off; larger values clamp to DIV_MAX.
  function automatic logic [DIV_W-1:0] eff_exp(input logic             div_en,
                                                input logic [DIV_W-1:0] div_val);
    logic [DIV_W-1:0] e;
    e = '0;
    if (div_en) begin
      e = (div_val > DIV_W'(DIV_MAX)) ? DIV_W'(DIV_MAX) : div_val;
    end
    return e;
  endfunction

  // 2^e - 1, computed one bit wider so e = DIV_MAX yields all-ones.
  function automatic logic [PRE_W-1:0] exp_limit(input logic [DIV_W-1:0] e);
    logic [PRE_W:0] p;
    p = (PRE_W+1)'(1) << e;
    return PRE_W'(p - (PRE_W+1)'(1));
  endfunction

  function automatic logic [PRE_W-1:0] div_limit(input logic             div_en,
                                                  input logic [DIV_W-1:0] div_val);
    return exp_limit(eff_exp(div_en, div_val));
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Power-of-two prescaler: owns the 8-bit `pre` counter and produces the
// count-enable pulse for the main counter.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   enable             : timer enable (pre held at 0 while low)
//   halt               : debug halt, freezes pre
//   e                  : effective exponent (already clamped)
//   cnt_en             : combinational; main counter increments at next edge
module cnt_prescaler
  import timer_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic             halt,
  input  logic [DIV_W-1:0] e,
  output logic             cnt_en
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [PRE_W-1:0] limit;

  assign limit = exp_limit(e);

  // Fire only on an exact match; a pre left above a newly lowered limit
  // wraps to 0 silently.
  always_comb begin
    pre_d  = pre_q;
    cnt_en = sys_rst_n & enable & ~halt & (pre_q == limit);
    if (!enable) begin
      pre_d = '0;
    end else if (!halt) begin
      pre_d = (pre_q >= limit) ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/cnt_core.sv
// Free-running 64-bit timer counter with power-of-two prescaler, byte-wise
// TDR0/TDR1 writes, timer_en falling-edge clear and debug halt.
//   sys_clk, sys_rst_n        : clock, async active-low reset
//   timer_en, div_en, div_val : enable and prescaler configuration
//   halt_req / halt_ack       : debug halt request / registered acknowledge
//   tdr0_wr_sel, tdr1_wr_sel  : write low / high counter word this cycle
//   tim_pstrb, tim_pwdata     : APB byte strobes and write data
//   cnt                       : live counter value
//   cnt_en                    : combinational count-enable pulse
// Optional (macro CNT_SNAPSHOT_EN):
//   tdr0_rd_sel / cnt_hi_snap : high word captured on a TDR0 read
module cnt_core
  import timer_pkg::*;
(
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               timer_en,
  input  logic               div_en,
  input  logic [DIV_W-1:0]   div_val,
  input  logic               halt_req,
  input  logic               tdr0_wr_sel,
  input  logic               tdr1_wr_sel,
  input  logic [STRB_N-1:0]  tim_pstrb,
  input  logic [WORD_W-1:0]  tim_pwdata,
`ifdef CNT_SNAPSHOT_EN
  input  logic               tdr0_rd_sel,
  output logic [WORD_W-1:0]  cnt_hi_snap,
`endif
  output logic [CNT_W-1:0]   cnt,
  output logic               cnt_en,
  output logic               halt_ack
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             en_q;
  logic             halt_ack_q;
  logic [DIV_W-1:0] e;
  logic             en_fall;
  logic             wr_any;
  tdr_wr_t          wr;

  assign e  = eff_exp(div_en, div_val);
  assign wr = '{strb: tim_pstrb, data: tim_pwdata};

  cnt_prescaler u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .enable    (timer_en),
    .halt      (halt_req),
    .e         (e),
    .cnt_en    (cnt_en)
  );

  // Next count: edge clear, else increment; written bytes then override,
  // and any write cancels that cycle's increment.
  always_comb begin
    en_fall = en_q & ~timer_en;
    wr_any  = tdr0_wr_sel | tdr1_wr_sel;
    cnt_d   = cnt_q;
    if (en_fall) begin
      cnt_d = '0;
    end else if (cnt_en && !wr_any) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    for (int k = 0; k < int'(STRB_N); k++) begin
      if (tdr0_wr_sel && wr.strb[k]) begin
        cnt_d[8*k +: 8] = wr.data[8*k +: 8];
      end
      if (tdr1_wr_sel && wr.strb[k]) begin
        cnt_d[WORD_W + 8*k +: 8] = wr.data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      en_q       <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      en_q       <= timer_en;
      halt_ack_q <= halt_req;
    end
  end

`ifdef CNT_SNAPSHOT_EN
  // High word frozen at the TDR0 read so a later TDR1 read is coherent.
  logic [WORD_W-1:0] snap_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap_q <= '0;
    end else if (tdr0_rd_sel) begin
      snap_q <= cnt_q[CNT_W-1:WORD_W];
    end
  end

  assign cnt_hi_snap = snap_q;
`endif

  assign cnt      = cnt_q;
  assign halt_ack = halt_ack_q;

endmodule

// File: tb/tb_cnt_core.sv
// Testbench for cnt_core: directed scenarios plus randomized traffic against
// a cycle-level reference model of the timer.
module tb_cnt_core;

  logic        clk;
  logic        rst_n;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_pwdata;
  logic [63:0] cnt;
  logic        cnt_en;
  logic        halt_ack;
`ifdef CNT_SNAPSHOT_EN
  logic        tdr0_rd_sel;
  logic [31:0] cnt_hi_snap;
`endif

  cnt_core dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .timer_en    (timer_en),
    .div_en      (div_en),
    .div_val     (div_val),
    .halt_req    (halt_req),
    .tdr0_wr_sel (tdr0_wr_sel),
    .tdr1_wr_sel (tdr1_wr_sel),
    .tim_pstrb   (tim_pstrb),
    .tim_pwdata  (tim_pwdata),
`ifdef CNT_SNAPSHOT_EN
    .tdr0_rd_sel (tdr0_rd_sel),
    .cnt_hi_snap (cnt_hi_snap),
`endif
    .cnt         (cnt),
    .cnt_en      (cnt_en),
    .halt_ack    (halt_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  logic [63:0] m_cnt;
  int          m_pre;
  bit          m_en_prev;
  bit          m_hack;
  logic [31:0] m_snap;

  function automatic int lim_now();
    int ex;
    if (!div_en) ex = 0;
    else ex = (int'(div_val) > 8) ? 8 : int'(div_val);
    return (1 << ex) - 1;
  endfunction

  function automatic bit m_fire();
    return rst_n && timer_en && !halt_req && (m_pre == lim_now());
  endfunction

  task automatic model_reset();
    m_cnt = '0; m_pre = 0; m_en_prev = 0; m_hack = 0; m_snap = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    logic [63:0] nc;
    logic [31:0] mk;
    int          lim;
    bit          fire;
    if (!rst_n) begin
      model_reset();
    end else begin
      lim  = lim_now();
      fire = m_fire();
      nc   = m_cnt;
      if (m_en_prev && !timer_en) nc = '0;
      else if (fire && !(tdr0_wr_sel || tdr1_wr_sel)) nc = m_cnt + 64'd1;
      for (int i = 0; i < 4; i++) mk[8*i +: 8] = {8{tim_pstrb[i]}};
      if (tdr0_wr_sel) nc[31:0]  = (nc[31:0]  & ~mk) | (tim_pwdata & mk);
      if (tdr1_wr_sel) nc[63:32] = (nc[63:32] & ~mk) | (tim_pwdata & mk);
`ifdef CNT_SNAPSHOT_EN
      if (tdr0_rd_sel) m_snap = m_cnt[63:32];
`endif
      if (!timer_en) m_pre = 0;
      else if (!halt_req) m_pre = (m_pre >= lim) ? 0 : m_pre + 1;
      m_cnt     = nc;
      m_en_prev = timer_en;
      m_hack    = halt_req;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr_wr();
    tdr0_wr_sel = 1'b0;
    tdr1_wr_sel = 1'b0;
    tim_pstrb   = 4'h0;
    tim_pwdata  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; timer_en = 1'b1; div_en = 1'b0; div_val = 4'd0;
    halt_req = 1'b1; clr_wr();
`ifdef CNT_SNAPSHOT_EN
    tdr0_rd_sel = 1'b0;
`endif
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) cyc();
    n_chk++; if (cnt !== 64'd0) $display("FAIL reset_cnt: got %h want 0", cnt); else n_pass++;
    n_chk++; if (cnt_en !== 1'b0) $display("FAIL reset_cnt_en: got %b want 0", cnt_en); else n_pass++;
    n_chk++; if (halt_ack !== 1'b0) $display("FAIL reset_halt_ack: got %b want 0", halt_ack); else n_pass++;
    halt_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_chk++; if (cnt_en !== 1'b1) $display("FAIL post_reset_cnt_en: got %b want 1", cnt_en); else n_pass++;
      cyc();
      n_chk++; if (cnt !== 64'(i)) $display("FAIL post_reset_cnt: got %h want %h", cnt, 64'(i)); else n_pass++;
    end
  endtask

  task automatic test_prescale();
    div_en = 1'b1; div_val = 4'd3; timer_en = 1'b0;
    cyc();
    timer_en = 1'b1;
    repeat (24) begin
      #1;
      n_chk++; if (cnt_en !== m_fire()) $display("FAIL div8_cnt_en: got %b want %b", cnt_en, m_fire()); else n_pass++;
      cyc();
    end
    n_chk++; if (cnt !== 64'd3) $display("FAIL div8_count: got %h want 3", cnt); else n_pass++;
    timer_en = 1'b0;
    cyc();
    div_val = 4'd12; timer_en = 1'b1;
    repeat (512) begin
      cyc();
      n_chk++; if (cnt !== m_cnt) $display("FAIL div256_track: got %h want %h", cnt, m_cnt); else n_pass++;
    end
    n_chk++; if (cnt !== 64'd2) $display("FAIL div256_count: got %h want 2", cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    div_en = 1'b0; timer_en = 1'b1;
    tdr1_wr_sel = 1'b1; tim_pstrb = 4'hF; tim_pwdata = 32'hFFFF_FFFF;
    cyc();
    tdr1_wr_sel = 1'b0; tdr0_wr_sel = 1'b1; tim_pwdata = 32'hFFFF_FFFE;
    #1;
    n_chk++; if (cnt_en !== 1'b1) $display("FAIL wrap_wr_cnt_en: got %b want 1", cnt_en); else n_pass++;
    cyc();
    n_chk++; if (cnt !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL wrap_load: got %h want fffffffffffffffe", cnt); else n_pass++;
    clr_wr();
    cyc();
    n_chk++; if (cnt !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_allones: got %h want ffffffffffffffff", cnt); else n_pass++;
    cyc();
    n_chk++; if (cnt !== 64'd0) $display("FAIL wrap_zero: got %h want 0", cnt); else n_pass++;
  endtask

  task automatic test_partial_write();
    tdr0_wr_sel = 1'b1; tim_pstrb = 4'hF; tim_pwdata = 32'h1234_5678;
    cyc();
    n_chk++; if (cnt !== 64'h1234_5678) $display("FAIL pw_load: got %h want 12345678", cnt); else n_pass++;
    tim_pstrb = 4'b0101; tim_pwdata = 32'hAABB_CCDD;
    cyc();
    n_chk++; if (cnt !== 64'h12BB_56DD) $display("FAIL pw_merge: got %h want 12bb56dd", cnt); else n_pass++;
    clr_wr();
    cyc();
    n_chk++; if (cnt !== 64'h12BB_56DE) $display("FAIL pw_resume: got %h want 12bb56de", cnt); else n_pass++;
  endtask

  task automatic test_halt();
    div_en = 1'b1; div_val = 4'd2; timer_en = 1'b0;
    cyc();
    timer_en = 1'b1;
    cyc();
    halt_req = 1'b1;
    #1;
    n_chk++; if (cnt_en !== 1'b0) $display("FAIL halt_cnt_en: got %b want 0", cnt_en); else n_pass++;
    repeat (5) begin
      cyc();
      n_chk++; if (halt_ack !== 1'b1) $display("FAIL halt_ack_hi: got %b want 1", halt_ack); else n_pass++;
      n_chk++; if (cnt !== 64'd0) $display("FAIL halt_frozen: got %h want 0", cnt); else n_pass++;
    end
    halt_req = 1'b0;
    cyc();
    n_chk++; if (halt_ack !== 1'b0) $display("FAIL halt_ack_lo: got %b want 0", halt_ack); else n_pass++;
    #1;
    n_chk++; if (cnt_en !== 1'b0) $display("FAIL halt_rel1_cnt_en: got %b want 0", cnt_en); else n_pass++;
    cyc();
    #1;
    n_chk++; if (cnt_en !== 1'b1) $display("FAIL halt_rel2_cnt_en: got %b want 1", cnt_en); else n_pass++;
    cyc();
    n_chk++; if (cnt !== 64'd1) $display("FAIL halt_resume: got %h want 1", cnt); else n_pass++;
  endtask

  task automatic test_disable();
    div_en = 1'b0; timer_en = 1'b1;
    tdr1_wr_sel = 1'b1; tim_pstrb = 4'hF; tim_pwdata = 32'h0;
    cyc();
    tdr1_wr_sel = 1'b0; tdr0_wr_sel = 1'b1; tim_pwdata = 32'h100;
    cyc();
    clr_wr();
    n_chk++; if (cnt !== 64'h100) $display("FAIL dis_load: got %h want 100", cnt); else n_pass++;
    timer_en = 1'b0;
    cyc();
    n_chk++; if (cnt !== 64'd0) $display("FAIL dis_clear: got %h want 0", cnt); else n_pass++;
    repeat (3) begin
      #1;
      n_chk++; if (cnt_en !== 1'b0) $display("FAIL dis_cnt_en: got %b want 0", cnt_en); else n_pass++;
      cyc();
      n_chk++; if (cnt !== 64'd0) $display("FAIL dis_hold: got %h want 0", cnt); else n_pass++;
    end
    tdr0_wr_sel = 1'b1; tim_pstrb = 4'b0001; tim_pwdata = 32'h55;
    cyc();
    clr_wr();
    cyc();
    n_chk++; if (cnt !== 64'h55) $display("FAIL dis_write: got %h want 55", cnt); else n_pass++;
    timer_en = 1'b1;
    cyc();
    timer_en = 1'b0; tdr0_wr_sel = 1'b1; tim_pstrb = 4'b0010; tim_pwdata = 32'h0000_AB00;
    cyc();
    clr_wr();
    n_chk++; if (cnt !== 64'hAB00) $display("FAIL fall_with_write: got %h want ab00", cnt); else n_pass++;
  endtask

`ifdef CNT_SNAPSHOT_EN
  task automatic test_snapshot();
    div_en = 1'b0; timer_en = 1'b1;
    tdr1_wr_sel = 1'b1; tim_pstrb = 4'hF; tim_pwdata = 32'h5;
    cyc();
    tdr1_wr_sel = 1'b0; tdr0_wr_sel = 1'b1; tim_pwdata = 32'h1;
    cyc();
    clr_wr();
    n_chk++; if (cnt !== 64'h5_0000_0001) $display("FAIL snap_load: got %h want 500000001", cnt); else n_pass++;
    tdr0_rd_sel = 1'b1;
    cyc();
    tdr0_rd_sel = 1'b0;
    n_chk++; if (cnt_hi_snap !== 32'h5) $display("FAIL snap_capture: got %h want 5", cnt_hi_snap); else n_pass++;
    tdr1_wr_sel = 1'b1; tim_pstrb = 4'hF; tim_pwdata = 32'h7;
    cyc();
    clr_wr();
    n_chk++; if (cnt_hi_snap !== 32'h5) $display("FAIL snap_hold: got %h want 5", cnt_hi_snap); else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      timer_en    = ($urandom_range(0, 15) != 0);
      div_en      = 1'($urandom);
      div_val     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
      halt_req    = ($urandom_range(0, 5) == 0);
      tdr0_wr_sel = ($urandom_range(0, 15) == 0);
      tdr1_wr_sel = ($urandom_range(0, 15) == 0);
      tim_pstrb   = 4'($urandom);
      tim_pwdata  = $urandom;
      if (($urandom_range(0, 31) == 0)) tim_pwdata = 32'hFFFF_FFFF;
`ifdef CNT_SNAPSHOT_EN
      tdr0_rd_sel = ($urandom_range(0, 7) == 0);
`endif
      #1;
      n_chk++; if (cnt_en !== m_fire()) $display("FAIL rnd_cnt_en[%0d]: got %b want %b", i, cnt_en, m_fire()); else n_pass++;
      cyc();
      n_chk++; if (cnt !== m_cnt) $display("FAIL rnd_cnt[%0d]: got %h want %h", i, cnt, m_cnt); else n_pass++;
      n_chk++; if (halt_ack !== m_hack) $display("FAIL rnd_halt_ack[%0d]: got %b want %b", i, halt_ack, m_hack); else n_pass++;
`ifdef CNT_SNAPSHOT_EN
      n_chk++; if (cnt_hi_snap !== m_snap) $display("FAIL rnd_snap[%0d]: got %h want %h", i, cnt_hi_snap, m_snap); else n_pass++;
`endif
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (cnt !== 64'd0) $display("FAIL rnd_async_reset[%0d]: got %h want 0", i, cnt); else n_pass++;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_wrap();
    test_partial_write();
    test_halt();
    test_disable();
`ifdef CNT_SNAPSHOT_EN
    test_snapshot();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
